// File: rtl/jpeg2bmp_mul_pipe_if.sv
// Sample bus of the JPEG datapath multiplier: operands in, scaled product out.
// The master drives operands; the multiplier (slave) returns dout/dout_vld/ovf.
interface jpeg2bmp_mul_pipe_if #(
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 41
);
    logic                  din_vld;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  dout_vld;
    logic [dout_WIDTH-1:0] dout;
    logic                  ovf;

    modport master (
        output din_vld, din0, din1,
        input  dout_vld, dout, ovf
    );

    modport slave (
        input  din_vld, din0, din1,
        output dout_vld, dout, ovf
    );
endinterface

// File: rtl/jpeg2bmp_mul_pipe.sv
// Pipelined multiply / rounded shift / narrow for the JPEG decode datapath.
// Optional clamp-on-overflow is built when JPEG2BMP_MUL_SAT_EN is defined.
module jpeg2bmp_mul_pipe #(
    parameter int din0_WIDTH  = 32,
    parameter int din1_WIDTH  = 10,
    parameter int dout_WIDTH  = 41,
    parameter int din0_SIGNED = 1,
    parameter int din1_SIGNED = 0,
    parameter int SHIFT       = 0,
    parameter int NUM_STAGE   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    jpeg2bmp_mul_pipe_if.slave bus
);
    localparam int P  = din0_WIDTH + din1_WIDTH + 1;
    localparam int SW = P + 1;
    localparam bit PS = (din0_SIGNED != 0) || (din1_SIGNED != 0);
    localparam logic [SW-1:0] RND =
        (SHIFT > 0) ? (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic signed [P-1:0] a_x, b_x, prod;
    logic [P-1:0]          fin_in;
    logic [SW-1:0]         rnd, scaled;
    logic [dout_WIDTH-1:0] narrow, res;
    logic                  res_ovf;
    logic [NUM_STAGE-1:0]  vld;
    logic [dout_WIDTH-1:0] dout_q;

    // Both operands widened to P bits so one signed multiply covers every mix
    always_comb begin
        if (din0_SIGNED != 0) a_x = P'($signed(bus.din0));
        else                  a_x = P'(bus.din0);
        if (din1_SIGNED != 0) b_x = P'($signed(bus.din1));
        else                  b_x = P'(bus.din1);
        prod = a_x * b_x;
    end

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign fin_in = prod;
        end else begin : g_dly
            logic [P-1:0] pipe [NUM_STAGE-1];
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < NUM_STAGE - 1; i++) pipe[i] <= '0;
                end else if (ce) begin
                    pipe[0] <= prod;
                    for (int i = 1; i < NUM_STAGE - 1; i++)
                        pipe[i] <= pipe[i-1];
                end
            end
            assign fin_in = pipe[NUM_STAGE-2];
        end
    endgenerate

    always_comb begin
        if (PS) begin
            rnd    = SW'($signed(fin_in)) + RND;
            scaled = $signed(rnd) >>> SHIFT;
            narrow = dout_WIDTH'($signed(scaled));
        end else begin
            rnd    = SW'(fin_in) + RND;
            scaled = rnd >> SHIFT;
            narrow = dout_WIDTH'(scaled);
        end
    end

`ifdef JPEG2BMP_MUL_SAT_EN
    logic ovf_q;

    generate
        if (dout_WIDTH < SW) begin : g_sat
            always_comb begin
                res     = narrow;
                res_ovf = 1'b0;
                if (PS) begin
                    if (!(&scaled[SW-1:dout_WIDTH-1]) &&
                        (|scaled[SW-1:dout_WIDTH-1])) begin
                        res_ovf = 1'b1;
                        res = {scaled[SW-1],
                               {(dout_WIDTH-1){~scaled[SW-1]}}};
                    end
                end else if (|scaled[SW-1:dout_WIDTH]) begin
                    res_ovf = 1'b1;
                    res     = '1;
                end
            end
        end else begin : g_fits
            assign res     = narrow;
            assign res_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset)  ovf_q <= 1'b0;
        else if (ce) ovf_q <= res_ovf;
    end

    assign bus.ovf = ovf_q;
`else
    assign res     = narrow;
    assign res_ovf = 1'b0;
    assign bus.ovf = res_ovf;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld    <= '0;
            dout_q <= '0;
        end else if (ce) begin
            vld    <= (vld << 1) | NUM_STAGE'(bus.din_vld);
            dout_q <= res;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld[NUM_STAGE-1];
endmodule
